s7_lap_ctrl: RTL

//  Stopwatch control stage between the BCD stopwatch counter and the 7-seg display driver.

---
 rtl/s7_lap_ctrl_pkg.sv | 19 +
 rtl/s7_lap_ctrl_debounce.sv | 52 +++++
 rtl/s7_lap_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/s7_lap_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encodings and
// the default BCD time bus width reused by the counter and display driver.
package s7_lap_ctrl_pkg;

    localparam int BCD_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_e;

    // The counter advances both while running and while a lap is displayed.
    function automatic logic is_counting(state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/s7_lap_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted rising level.
module s7_debounce
    import s7_lap_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronize, count consecutive disagreeing cycles, accept level after the full run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= i_raw;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
                // A flip only happens on disagreement, so a new level of 1 is a rise.
                press_q  <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_level = stable_q;
    assign o_press = press_q;

endmodule

// File: rtl/s7_lap_ctrl.sv
// Stopwatch control stage: debounced START/STOP and LAP/RESET buttons drive a
// 4-state FSM that enables/clears the counter and selects live or lap time.
module s7_lap_ctrl
    import s7_lap_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BCD_W           = BCD_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn_start,
    input  logic             i_btn_lap,
    input  logic [BCD_W-1:0] i_bcd_time,
    output logic             o_cnt_en,
    output logic             o_cnt_clr,
    output logic [BCD_W-1:0] o_bcd_data,
    output logic             o_lap_active
);

    logic start_level, start_press;
    logic lap_level, lap_press;
    logic ps, pl;

    state_e           state_q, state_d;
    logic [BCD_W-1:0] snap_q, snap_d;
    logic             clr_d;
    logic             cnt_en_q, clr_q, lap_q;
    logic [BCD_W-1:0] bcd_q;

    s7_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_btn_start),
        .o_level (start_level),
        .o_press (start_press)
    );

    s7_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lap (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_btn_lap),
        .o_level (lap_level),
        .o_press (lap_press)
    );

    // A press pulse always coincides with the debounced level being high.
    assign ps = start_press & start_level;
    assign pl = lap_press & lap_level;

    // Next-state logic; START has priority, a simultaneous LAP press is dropped.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        clr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ps)      state_d = ST_RUN;
                else if (pl) clr_d   = 1'b1;
            end
            ST_RUN: begin
                if (ps) begin
                    state_d = ST_PAUSE;
                end else if (pl) begin
                    state_d = ST_LAP;
                    snap_d  = i_bcd_time;
                end
            end
            ST_LAP: begin
                if (ps)      state_d = ST_PAUSE;
                else if (pl) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (ps) begin
                    state_d = ST_RUN;
                end else if (pl) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, snapshot and Moore outputs registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            snap_q   <= '0;
            cnt_en_q <= 1'b0;
            clr_q    <= 1'b0;
            lap_q    <= 1'b0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            cnt_en_q <= is_counting(state_d);
            clr_q    <= clr_d;
            lap_q    <= (state_d == ST_LAP);
            bcd_q    <= (state_d == ST_LAP) ? snap_d : i_bcd_time;
        end
    end

    assign o_cnt_en     = cnt_en_q;
    assign o_cnt_clr    = clr_q;
    assign o_lap_active = lap_q;
    assign o_bcd_data   = bcd_q;

endmodule
